// File: rtl/reg_arb_pkg.sv
// Shared types and defaults for the register-sharing arbiter.
// State encoding, default sizing and a pointer-width helper.
package reg_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int DEF_N        = 4;
    localparam int DEF_WIDTH    = 32;
    localparam int DEF_MAX_LOCK = 4;

    // Width of a requester index, at least one bit.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first request at or after ptr.
// Rotate, isolate the lowest set bit, rotate back.
module rr_pick
    import reg_arb_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int PW = ptr_w(DEF_N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  win,
    output logic          valid
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] back;
    logic [N-1:0]   rot;
    logic [N-1:0]   first;

    // Rotate so ptr sits at bit 0, pick lowest, rotate back.
    always_comb begin
        dbl   = {req, req} >> ptr;
        rot   = dbl[N-1:0];
        first = rot & (~rot + N'(1));
        back  = {first, first} << ptr;
        win   = back[2*N-1:N];
        valid = |req;
    end

endmodule

// File: rtl/reg_share_arb.sv
// Round-robin arbiter granting N writers access to one enabled register.
// Optional burst hold per grant when ARB_LOCK_EN is defined.
module reg_share_arb
    import reg_arb_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int MAX_LOCK = DEF_MAX_LOCK
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic [N-1:0]         req,
    input  logic [N*WIDTH-1:0]   wdata,
    input  logic [N-1:0]         lock,
    output logic [N-1:0]         gnt,
    output logic [N-1:0]         ack,
    output logic [WIDTH-1:0]     d,
    output logic                 e,
    output logic [15:0]          wr_cnt
);

    localparam int PW = ptr_w(N);

    state_t          state;
    state_t          state_n;
    logic [N-1:0]    gnt_n;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_n;
    logic [PW-1:0]   w;
    logic [PW-1:0]   ptr_inc;
    logic            commit;
    logic            hold;
    logic [N-1:0]    pick_req;
    logic [PW-1:0]   pick_ptr;
    logic [N-1:0]    win;
    logic            pick_valid;
    logic [WIDTH-1:0] dsel;

    // Index of the current grant holder and its data slice.
    always_comb begin
        w    = '0;
        dsel = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                w    = PW'(i);
                dsel = wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    assign ptr_inc = (w == PW'(N - 1)) ? '0 : w + PW'(1);
    assign commit  = (state == GRANT) && |(gnt & req);

    // After a commit the just-served requester goes to the back.
    assign pick_req = commit ? (req & ~gnt) : req;
    assign pick_ptr = commit ? ptr_inc : ptr;

    rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .req   (pick_req),
        .ptr   (pick_ptr),
        .win   (win),
        .valid (pick_valid)
    );

`ifdef ARB_LOCK_EN
    localparam int LW = $clog2(MAX_LOCK + 1);

    logic [LW-1:0] lock_cnt;
    logic [LW-1:0] lock_cnt_n;

    assign hold = commit && |(gnt & lock)
               && ((int'(lock_cnt) + 1) < MAX_LOCK);
    assign lock_cnt_n = hold ? lock_cnt + LW'(1) : '0;

    // Consecutive writes made under the current held grant.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            lock_cnt <= '0;
        end else begin
            lock_cnt <= lock_cnt_n;
        end
    end
`else
    logic unused_lock;

    assign hold        = 1'b0;
    assign unused_lock = ^{lock, 32'(MAX_LOCK)};
`endif

    // State, grant, pointer and write counter registers.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state  <= IDLE;
            gnt    <= '0;
            ptr    <= '0;
            wr_cnt <= '0;
        end else begin
            state  <= state_n;
            gnt    <= gnt_n;
            ptr    <= ptr_n;
            if (commit) begin
                wr_cnt <= wr_cnt + 16'd1;
            end
        end
    end

    // Next grant: hold, re-arbitrate, or fall back to idle.
    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        ptr_n   = ptr;
        unique case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_n = GRANT;
                    gnt_n   = win;
                end
            end
            GRANT: begin
                if (commit) begin
                    ptr_n = ptr_inc;
                end
                if (!hold) begin
                    if (pick_valid) begin
                        state_n = GRANT;
                        gnt_n   = win;
                    end else begin
                        state_n = IDLE;
                        gnt_n   = '0;
                    end
                end
            end
        endcase
    end

    // Write strobe, data and ack follow the grant combinationally.
    always_comb begin
        e   = commit;
        ack = commit ? gnt : '0;
        d   = commit ? dsel : '0;
    end

endmodule

// File: doc/reg_share_arb.md
REG_SHARE_ARB -- requirements
Module: reg_share_arb

Interface
- REQ-001: Parameter N, default 4: number of requesters.
- REQ-002: Parameter WIDTH, default 32: data width of the shared register.
- REQ-003: Parameter MAX_LOCK, default 4: maximum consecutive locked writes per grant.
- REQ-004: Clock and reset: one clock; reset is asynchronous and active-high.
- REQ-005: clk  input  1  clock; all state changes on the rising edge.
- REQ-006: clr  input  1  asynchronous active-high clear.
- REQ-007: req  input  N  per-requester write request; held high until ack.
- REQ-008: wdata  input  N*WIDTH  per-requester write data; slice i is wdata[i*WIDTH +: WIDTH], held stable until ack.
- REQ-009: lock  input  N  per-requester burst-hold request; used only when ARB_LOCK_EN is defined.
- REQ-010: gnt  output  N  one-hot grant, registered.
- REQ-011: ack  output  N  one-cycle pulse, in the cycle the write commits.
- REQ-012: d  output  WIDTH  data to the shared enabled register.
- REQ-013: e  output  1  write enable to the shared enabled register.
- REQ-014: wr_cnt  output  16  count of committed writes.

Function
- REQ-015: FSM states are IDLE and GRANT; the reset state is IDLE.
- REQ-016: IDLE with any req bit high: on the next edge, select winner w round-robin starting at pointer ptr; load gnt = 1<<w; go to GRANT.
- REQ-017: GRANT with req[w]=1: e=1, d=wdata slice w, ack[w]=1, all combinational from state, gnt and req.
- REQ-018: GRANT with req[w]=0 (abort): e=0, no ack; ptr unchanged; re-arbitrate exactly as from IDLE.
- REQ-019: After a committed write, ptr = (w+1) mod N.
- REQ-020: Leaving GRANT: re-arbitrate among the pending requests (excluding the just-acked one unless locked); go to GRANT with the new winner, or to IDLE if none pending.
- REQ-021: Latency: request to write is 1 cycle from IDLE; sustained throughput is one write per cycle under contention.
- REQ-022: Fairness: with all N requesters requesting, each requester is served once in every N consecutive writes.
- REQ-023: Pointer wrap: ptr = N-1 searches N-1, 0, 1, ...
- REQ-024: wr_cnt increments on each committed write and wraps 0xFFFF -> 0x0000.
- REQ-025: No more than one gnt bit and one ack bit are high in any cycle.
- REQ-026: d = 0 whenever e = 0.

Reset
- REQ-027: Asserting clr immediately forces the state to IDLE; gnt=0, ack=0, e=0, d=0, ptr=0, lock counter=0, wr_cnt=0, regardless of the clock.
- REQ-028: clr asserted mid-GRANT drops e within the same cycle; the interrupted write is not committed or acked.
- REQ-029: After clr deasserts, arbitration resumes on the first rising edge with ptr=0.

Configuration
- REQ-030: Macro ARB_LOCK_EN defined: after a commit, if lock[w]=1 and req[w]=1, w keeps the grant for the next cycle without re-arbitration.
- REQ-031: Lock hold is capped at MAX_LOCK consecutive writes; after that, re-arbitration is forced and ptr advances.
- REQ-032: Macro ARB_LOCK_EN undefined: the lock input is ignored, no lock counter is built, and behaviour equals REQ-015 to REQ-026.

Structure
- REQ-033: Shared package reg_arb_pkg holds the state encoding (IDLE, GRANT) and the default constants N, WIDTH, MAX_LOCK.
- REQ-034: One combinational sub-module rr_pick(req, ptr) -> one-hot winner plus a valid flag; it is used for every arbitration decision.

Verification
- REQ-035: Bench drives d and e into a 32-bit enabled register with clear and checks its q against a reference model.
- REQ-036: Single request: req=0001, wdata0=0x12345678 -> gnt=0001 next cycle, e=1, ack0 pulse, register q=0x12345678 one edge later, wr_cnt=1.
- REQ-037: All-request contention: req=1111 held, each requester re-requesting after ack -> commit order 0,1,2,3,0; one write per cycle; exactly one gnt bit per cycle.
- REQ-038: Abort: req2 dropped during its GRANT cycle -> e=0, no ack2, q unchanged, ptr still 2, next winner chosen from the remaining requests.
- REQ-039: Async reset mid-GRANT: clr pulsed between edges -> e=0 and gnt=0 immediately, q not updated, wr_cnt=0, first grant after release goes to the lowest pending index.
- REQ-040: With ARB_LOCK_EN, lock0=1 and req=0011 -> requester 0 gets 4 consecutive writes, then requester 1 is granted. Without ARB_LOCK_EN -> 0,1,0,1 alternation.
- REQ-041: wr_cnt preset by 65535 writes -> next commit gives wr_cnt=0x0000.
